// File: rtl/gps_code_capture.sv
// -----------------------------------------------------------------------------
// gps_code_capture
//
// Captures one snapshot of the upstream GPS code words (C/A, P and L code) on
// every rising edge of l_code_valid and queues it in a small
// first-word-fall-through FIFO. The consumer sees the oldest snapshot on the
// rd_* outputs whenever rd_valid is high and pops it with rd_en.
//
// A capture that arrives while the FIFO is full (and is not relieved by a pop
// in the same cycle) is dropped: the FIFO contents stay as they are, the sticky
// overflow flag is set and drop_count increments, saturating at 255.
//
// Optional feature (compile-time macro GPS_CODE_CAPTURE_TIMESTAMP_EN):
//   A 32-bit free-running cycle counter is added. Every entry also stores the
//   counter value of its capture cycle, presented on rd_timestamp. Without the
//   macro, the counter and the rd_timestamp port do not exist.
//
// Parameters
//   DEPTH          number of FIFO entries (power of two, 2..16)
//   CNT_W          width of the occupancy count (holds 0..DEPTH)
//
// Ports
//   sys_clk        in   1    single clock, rising edge
//   sync_rst_in    in   1    synchronous active-high reset
//   ca_code        in   13   C/A code word from upstream
//   p_code         in   128  P-code word from upstream
//   l_code         in   128  L-code word from upstream
//   l_code_valid   in   1    upstream code-valid level; 0->1 is a capture
//   flush          in   1    empty the FIFO (beats capture and pop)
//   rd_en          in   1    pop the head entry (ignored while empty)
//   clear_overflow in   1    clear overflow and drop_count
//   rd_valid       out  1    FIFO non-empty, head presented on rd_*
//   rd_ca_code     out  13   head C/A code (0 while empty)
//   rd_p_code      out  128  head P-code   (0 while empty)
//   rd_l_code      out  128  head L-code   (0 while empty)
//   count          out  CNT_W number of entries held
//   overflow       out  1    sticky dropped-capture flag
//   drop_count     out  8    saturating count of dropped captures
//   rd_timestamp   out  32   head capture cycle (macro builds only, 0 while empty)
// -----------------------------------------------------------------------------
module gps_code_capture #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               sys_clk,
    input  logic               sync_rst_in,
    input  logic [12:0]        ca_code,
    input  logic [127:0]       p_code,
    input  logic [127:0]       l_code,
    input  logic               l_code_valid,
    input  logic               flush,
    input  logic               rd_en,
    input  logic               clear_overflow,
    output logic               rd_valid,
    output logic [12:0]        rd_ca_code,
    output logic [127:0]       rd_p_code,
    output logic [127:0]       rd_l_code,
    output logic [CNT_W-1:0]   count,
    output logic               overflow,
    output logic [7:0]         drop_count
`ifdef GPS_CODE_CAPTURE_TIMESTAMP_EN
    ,
    output logic [31:0]        rd_timestamp
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [7:0]       DROP_MAX = 8'hFF;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic              valid_q;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    logic [12:0]       mem_ca [DEPTH];
    logic [127:0]      mem_p  [DEPTH];
    logic [127:0]      mem_l  [DEPTH];

`ifdef GPS_CODE_CAPTURE_TIMESTAMP_EN
    logic [31:0]       cycle_cnt;
    logic [31:0]       mem_ts [DEPTH];
`endif

    // -------------------------------------------------------------------------
    // Event decode
    // -------------------------------------------------------------------------
    logic capture;   // rising edge of l_code_valid
    logic full;
    logic do_pop;    // head entry leaves the FIFO
    logic do_push;   // captured words enter the FIFO
    logic do_drop;   // capture lost because the FIFO is full

    assign capture  = l_code_valid & ~valid_q;
    assign full     = (count == FULL_CNT);
    assign rd_valid = (count != '0);

    // Flush wins over everything in its cycle: the capture it coincides with
    // is discarded outright rather than being treated as a drop.
    assign do_pop  = rd_en & rd_valid & ~flush;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign do_push = capture & ~flush & (~full | do_pop);
    assign do_drop = capture & ~flush & full & ~do_pop;

    // -------------------------------------------------------------------------
    // Control state: edge detector, pointers, occupancy, overflow status
    // -------------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge sys_clk) begin
        if (sync_rst_in) begin
            valid_q    <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            // Tracked during flush too, so a held-high level is not recaptured
            // once the flush is over.
            valid_q <= l_code_valid;

            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                // Pointer widths equal log2(DEPTH), so the increment wraps
                // modulo DEPTH on its own.
                if (do_push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (do_push && !do_pop) begin
                    count <= count + CNT_W'(1);
                end else if (do_pop && !do_push) begin
                    count <= count - CNT_W'(1);
                end
            end

            // A drop in the same cycle as a clear is kept as the first event
            // after the clear, so it is never silently lost.
            if (clear_overflow) begin
                overflow   <= do_drop;
                drop_count <= do_drop ? 8'd1 : 8'd0;
            end else if (do_drop) begin
                overflow <= 1'b1;
                if (drop_count != DROP_MAX) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset; an entry is only ever observed
    // after it has been written, and leaving it unreset lets it map to RAM.
    always_ff @(posedge sys_clk) begin
        if (!sync_rst_in && do_push) begin
            mem_ca[wr_ptr] <= ca_code;
            mem_p[wr_ptr]  <= p_code;
            mem_l[wr_ptr]  <= l_code;
`ifdef GPS_CODE_CAPTURE_TIMESTAMP_EN
            mem_ts[wr_ptr] <= cycle_cnt;
`endif
        end
    end

`ifdef GPS_CODE_CAPTURE_TIMESTAMP_EN
    // Free-running cycle counter; wraps 0xFFFFFFFF -> 0 by width.
    always_ff @(posedge sys_clk) begin
        if (sync_rst_in) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Head presentation (first-word-fall-through)
    // -------------------------------------------------------------------------
    // The head is read straight out of storage, so a pushed entry shows up the
    // cycle after its capture and stays put until it is popped. Outputs are
    // forced to zero while empty because the storage itself is never cleared.
    // NOTE: every output gets a default before the conditional assignment so
    // this block stays purely combinational and cannot infer a latch.
    always_comb begin
        rd_ca_code = '0;
        rd_p_code  = '0;
        rd_l_code  = '0;
`ifdef GPS_CODE_CAPTURE_TIMESTAMP_EN
        rd_timestamp = '0;
`endif
        if (rd_valid) begin
            rd_ca_code = mem_ca[rd_ptr];
            rd_p_code  = mem_p[rd_ptr];
            rd_l_code  = mem_l[rd_ptr];
`ifdef GPS_CODE_CAPTURE_TIMESTAMP_EN
            rd_timestamp = mem_ts[rd_ptr];
`endif
        end
    end

endmodule

// File: tb/tb_gps_code_capture.sv
// -----------------------------------------------------------------------------
// tb_gps_code_capture
//
// Self-checking bench for gps_code_capture (DEPTH = 4). Directed scenarios
// cover single capture, level hold, full/drop, full with pop, flush against
// capture, drop_count saturation and (macro builds) timestamps; a long random
// run follows. Every cycle the outputs are compared with a queue-based
// reference model of the capture FIFO.
// -----------------------------------------------------------------------------
module tb_gps_code_capture;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               sys_clk = 1'b0;
    logic               sync_rst_in;
    logic [12:0]        ca_code;
    logic [127:0]       p_code;
    logic [127:0]       l_code;
    logic               l_code_valid;
    logic               flush;
    logic               rd_en;
    logic               clear_overflow;
    logic               rd_valid;
    logic [12:0]        rd_ca_code;
    logic [127:0]       rd_p_code;
    logic [127:0]       rd_l_code;
    logic [CNT_W-1:0]   count;
    logic               overflow;
    logic [7:0]         drop_count;
`ifdef GPS_CODE_CAPTURE_TIMESTAMP_EN
    logic [31:0]        rd_timestamp;
`endif

    gps_code_capture #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .sys_clk        (sys_clk),
        .sync_rst_in    (sync_rst_in),
        .ca_code        (ca_code),
        .p_code         (p_code),
        .l_code         (l_code),
        .l_code_valid   (l_code_valid),
        .flush          (flush),
        .rd_en          (rd_en),
        .clear_overflow (clear_overflow),
        .rd_valid       (rd_valid),
        .rd_ca_code     (rd_ca_code),
        .rd_p_code      (rd_p_code),
        .rd_l_code      (rd_l_code),
        .count          (count),
        .overflow       (overflow),
        .drop_count     (drop_count)
`ifdef GPS_CODE_CAPTURE_TIMESTAMP_EN
        ,
        .rd_timestamp   (rd_timestamp)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    // ------------------------------------------------------------------ model
    typedef struct {
        logic [12:0]  ca;
        logic [127:0] p;
        logic [127:0] l;
        logic [31:0]  ts;
    } entry_t;

    entry_t      m_q[$];
    logic        m_prev_valid;
    logic        m_ovf;
    int          m_drops;
    logic [31:0] m_cycle;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock of the reference: applies the rules to the inputs of this cycle.
    task automatic model_cycle();
        bit cap, popped, full;
        if (sync_rst_in) begin
            m_q.delete();
            m_prev_valid = 1'b0;
            m_ovf        = 1'b0;
            m_drops      = 0;
            m_cycle      = 32'd0;
            return;
        end
        cap  = l_code_valid && !m_prev_valid;
        m_prev_valid = l_code_valid;
        full = (m_q.size() == DEPTH);
        if (flush) begin
            m_q.delete();
            cap = 1'b0;
        end else begin
            popped = rd_en && (m_q.size() > 0);
            if (popped) void'(m_q.pop_front());
            if (cap && full && !popped) begin
                if (clear_overflow) begin
                    m_ovf = 1'b1; m_drops = 1;
                end else begin
                    m_ovf = 1'b1; m_drops = (m_drops < 255) ? m_drops + 1 : 255;
                end
                cap = 1'b0;
                m_cycle = m_cycle + 32'd1;
                return;
            end
            if (cap) m_q.push_back('{ca: ca_code, p: p_code, l: l_code, ts: m_cycle});
        end
        if (clear_overflow) begin
            m_ovf = 1'b0; m_drops = 0;
        end
        m_cycle = m_cycle + 32'd1;
    endtask

    task automatic compare_all();
        entry_t h;
        h = '{ca: '0, p: '0, l: '0, ts: '0};
        if (m_q.size() > 0) h = m_q[0];
        check("rd_valid",   rd_valid,   m_q.size() > 0);
        check("count",      count,      m_q.size());
        check("overflow",   overflow,   m_ovf);
        check("drop_count", drop_count, m_drops);
        check("rd_ca_code", rd_ca_code, h.ca);
        check("rd_p_code",  rd_p_code,  h.p);
        check("rd_l_code",  rd_l_code,  h.l);
`ifdef GPS_CODE_CAPTURE_TIMESTAMP_EN
        check("rd_timestamp", rd_timestamp, h.ts);
`endif
    endtask

    // Apply one cycle of inputs, advance the model, and compare after the edge.
    task automatic drive(input logic rst, input logic lv, input logic [12:0] ca,
                         input logic [127:0] p, input logic [127:0] l,
                         input logic fl, input logic re, input logic clr);
        sync_rst_in    = rst;
        l_code_valid   = lv;
        ca_code        = ca;
        p_code         = p;
        l_code         = l;
        flush          = fl;
        rd_en          = re;
        clear_overflow = clr;
        @(posedge sys_clk);
        model_cycle();
        #1;
        compare_all();
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic idle(input logic lv);
        drive(1'b0, lv, 13'($urandom), rnd128(), rnd128(), 1'b0, 1'b0, 1'b0);
    endtask

    // Produce one capture event (low then high) with random data, no reads.
    task automatic pulse(output logic [12:0] ca);
        ca = 13'($urandom);
        idle(1'b0);
        drive(1'b0, 1'b1, ca, rnd128(), rnd128(), 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [12:0] first_ca;
        logic [12:0] cas[6];
        logic        rst, lv, fl, re, clr;

        // ---------------------------------------------------------- reset
        drive(1'b1, 1'b1, 13'h1FFF, '1, '1, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("reset_count", count, 0);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_rd_ca_code", rd_ca_code, 0);

        // --------------------------------------------------- single capture
        drive(1'b0, 1'b1, 13'h1ABC, 128'h1, 128'hF0, 1'b0, 1'b0, 1'b0);
        check("single_rd_valid", rd_valid, 1);
        check("single_count", count, 1);
        check("single_ca", rd_ca_code, 13'h1ABC);
        check("single_p", rd_p_code, 128'h1);
        check("single_l", rd_l_code, 128'hF0);
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        check("single_pop_rd_valid", rd_valid, 0);
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);   // rd_en while empty
        check("empty_pop_count", count, 0);

        // --------------------------------------------------------- level hold
        first_ca = 13'h0555;
        drive(1'b0, 1'b1, first_ca, rnd128(), rnd128(), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) idle(1'b1);
        check("hold_count", count, 1);
        check("hold_ca", rd_ca_code, first_ca);
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);

        // ---------------------------------------------------------- full/drop
        for (int i = 0; i < 6; i++) pulse(cas[i]);
        check("full_count", count, 4);
        check("full_overflow", overflow, 1);
        check("full_drop_count", drop_count, 2);
        check("full_head_ca", rd_ca_code, cas[0]);
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("clear_overflow", overflow, 0);
        check("clear_drop_count", drop_count, 0);

        // ------------------------------------------ full with simultaneous pop
        drive(1'b0, 1'b1, 13'h0ABC, rnd128(), rnd128(), 1'b0, 1'b1, 1'b0);
        check("fullpop_count", count, 4);
        check("fullpop_overflow", overflow, 0);
        check("fullpop_head_ca", rd_ca_code, cas[1]);

        // --------------------------------------------- flush versus capture
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        check("preflush_count", count, 3);
        drive(1'b0, 1'b1, 13'h0777, rnd128(), rnd128(), 1'b1, 1'b0, 1'b0);
        check("flush_count", count, 0);
        check("flush_rd_valid", rd_valid, 0);
        idle(1'b1);   // level still high after flush: no new capture
        check("flush_hold_count", count, 0);

        // --------------------------------------------- drop_count saturation
        for (int i = 0; i < DEPTH + 260; i++) pulse(first_ca);
        check("sat_drop_count", drop_count, 255);
        check("sat_overflow", overflow, 1);
        // drop coinciding with clear_overflow
        idle(1'b0);
        drive(1'b0, 1'b1, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("dropclr_overflow", overflow, 1);
        check("dropclr_drop_count", drop_count, 1);

`ifdef GPS_CODE_CAPTURE_TIMESTAMP_EN
        // ------------------------------------------------------- timestamps
        drive(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 13; k++)
            drive(1'b0, (k == 5 || k == 12), 13'(k), rnd128(), rnd128(), 1'b0, 1'b0, 1'b0);
        check("ts_first", rd_timestamp, 32'd5);
        drive(1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        check("ts_second", rd_timestamp, 32'd12);
        drive(1'b1, 1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);   // reset while count=1
        check("ts_reset_count", count, 0);
        drive(1'b0, 1'b1, '0, '0, '0, 1'b0, 1'b0, 1'b0);   // capture right after reset
        check("ts_after_reset", rd_timestamp, 32'd0);
`endif

        // ------------------------------------------- capture right after reset
        drive(1'b1, 1'b1, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 13'h0123, rnd128(), rnd128(), 1'b0, 1'b0, 1'b0);
        check("post_reset_capture_count", count, 1);
        check("post_reset_capture_ca", rd_ca_code, 13'h0123);

        // ------------------------------------------------------------ random
        for (int i = 0; i < 4000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            lv  = ($urandom_range(0, 2) != 0) ? ~l_code_valid : l_code_valid;
            fl  = ($urandom_range(0, 39) == 0);
            re  = ($urandom_range(0, 2) == 0);
            clr = ($urandom_range(0, 24) == 0);
            // Keep flush away from a capture that would otherwise be a drop.
            if (m_q.size() == DEPTH && lv && !m_prev_valid) fl = 1'b0;
            drive(rst, lv, 13'($urandom), rnd128(), rnd128(), fl, re, clr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/gps_code_capture.md
GPS_CODE_CAPTURE -- requirements
Module: gps_code_capture

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of capture FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter CNT_W, default $clog2(DEPTH)+1, giving the width of the occupancy count.
REQ-003 Port sys_clk  input  1  is the single clock; all logic SHALL be rising-edge sys_clk.
REQ-004 Port sync_rst_in  input  1  is the reset, synchronous and active-high.
REQ-005 Port ca_code  input  13  is the C/A code word from the upstream GPS mock-TSS stage.
REQ-006 Port p_code  input  128  is the P-code word from upstream.
REQ-007 Port l_code  input  128  is the L-code word from upstream.
REQ-008 Port l_code_valid  input  1  is the upstream code-valid level.
REQ-009 Port flush  input  1  empties the FIFO.
REQ-010 Port rd_en  input  1  pops the head entry.
REQ-011 Port clear_overflow  input  1  clears overflow status.
REQ-012 Port rd_valid  output  1  means the FIFO is non-empty and the head is presented.
REQ-013 Ports rd_ca_code, rd_p_code and rd_l_code  output  13/128/128  carry the head entry fields.
REQ-014 Port count  output  CNT_W  is the current number of entries.
REQ-015 Port overflow  output  1  is the sticky dropped-capture flag.
REQ-016 Port drop_count  output  8  is the saturating count of dropped captures.

Function
REQ-017 A capture event SHALL occur in a cycle where l_code_valid=1 and the registered previous value valid_q=0.
REQ-018 A capture SHALL sample ca_code, p_code and l_code from that same cycle.
REQ-019 The FIFO SHALL be first-word-fall-through.
REQ-020 rd_valid and the head fields SHALL update the cycle after the push (1-cycle latency from event to rd_valid).
REQ-021 rd_valid SHALL equal (count!=0).
REQ-022 The head fields SHALL hold their value while rd_valid=1 and rd_en=0.
REQ-023 A pop SHALL occur only when rd_en=1 and rd_valid=1.
REQ-024 rd_en while empty SHALL be ignored, with no state change.
REQ-025 With simultaneous capture and pop, both SHALL occur and count SHALL be unchanged, including when full.
REQ-026 A capture while full with no pop SHALL be dropped with contents unchanged, overflow set to 1, and drop_count incremented, saturating at 255.
REQ-027 Read/write pointers SHALL wrap modulo DEPTH, and count SHALL range 0..DEPTH.
REQ-028 flush=1 SHALL make count=0 and rd_valid=0 next cycle, with priority over capture and pop in that cycle.
REQ-029 flush SHALL NOT alter overflow or drop_count.
REQ-030 clear_overflow=1 SHALL zero overflow and drop_count next cycle.
REQ-031 If a drop coincides with clear_overflow, the result SHALL be overflow=1 and drop_count=1.
REQ-032 Holding l_code_valid high SHALL yield exactly one capture per 0->1 transition.

Reset
REQ-033 On sync_rst_in=1, valid_q, pointers, count, overflow and drop_count SHALL be 0, rd_valid SHALL be 0, and rd_* fields SHALL be 0.
REQ-034 Reset SHALL override flush, rd_en and capture in the same cycle, and SHALL discard any in-progress contents.
REQ-035 If l_code_valid=1 in the first cycle after reset deasserts, that cycle SHALL count as a capture event, since valid_q resets to 0.
REQ-036 FIFO storage RAM need not be reset, but the rd_* outputs SHALL read 0 while empty.

Configuration
REQ-037 With GPS_CODE_CAPTURE_TIMESTAMP_EN defined, the block SHALL have a 32-bit free-running cycle counter, reset to 0, incrementing every cycle and wrapping 0xFFFFFFFF->0.
REQ-038 With GPS_CODE_CAPTURE_TIMESTAMP_EN defined, each entry SHALL store the counter value of its capture cycle, presented on output port rd_timestamp [31:0] (0 while empty).
REQ-039 Without GPS_CODE_CAPTURE_TIMESTAMP_EN, rd_timestamp and the counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-040 Single capture: after reset, l_code_valid 0->1 with ca=0x1ABC, p=128'h1, l=128'hF0 -> next cycle rd_valid=1, count=1, fields match; rd_en -> rd_valid=0.
REQ-041 Level hold: l_code_valid high 10 cycles with changing data -> exactly 1 entry, holding the first-cycle data.
REQ-042 Full/drop: with DEPTH=4, 6 capture events and no reads -> count=4, overflow=1, drop_count=2, entries equal the first 4 in order; clear_overflow -> overflow=0, drop_count=0.
REQ-043 Full with simultaneous pop: at full, capture plus rd_en same cycle -> count stays 4, no overflow, head advances, new data at tail.
REQ-044 Flush vs capture: capture edge coincident with flush at count=3 -> next cycle count=0, overflow unchanged.
REQ-045 Timestamp (macro on): reset, capture edges at cycles 5 and 12 after reset -> rd_timestamp reads 5 then 12; reset mid-operation at count=2 -> count=0 and counter=0 next cycle.
